// File: rtl/cpu_debug_pkg.sv
// -----------------------------------------------------------------------------
// cpu_debug_pkg
// Shared types and constants for the CPU run/step/breakpoint controller.
//   - state_t     : controller FSM states
//   - watch_sel_t : LED watch-mux select codes, in display mux order
//   - FETCH_STAT_DEFAULT : CPU FSM state that marks an instruction boundary
// -----------------------------------------------------------------------------
package cpu_debug_pkg;

    typedef enum logic [1:0] {
        HALT      = 2'd0,
        STEP_CYC  = 2'd1,
        STEP_INST = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [3:0] FETCH_STAT_DEFAULT = 4'd0;

    typedef enum logic [3:0] {
        WSEL_STAT          = 4'd0,
        WSEL_PC            = 4'd1,
        WSEL_IR            = 4'd2,
        WSEL_RS1           = 4'd3,
        WSEL_RS2           = 4'd4,
        WSEL_RD            = 4'd5,
        WSEL_WB_DATA       = 4'd6,
        WSEL_IMM32         = 4'd7,
        WSEL_LHS           = 4'd8,
        WSEL_RHS           = 4'd9,
        WSEL_ALU_OP        = 4'd10,
        WSEL_ALU_F         = 4'd11,
        WSEL_ALU_FLAGS     = 4'd12,
        WSEL_MDR           = 4'd13,
        WSEL_WB_DATA_SEL   = 4'd14,
        WSEL_PC_UPDATE_SEL = 4'd15
    } watch_sel_t;

endpackage

// File: rtl/cpu_debug_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_debug_ctrl_if
// Link between the debug controller and the CPU core.
//   cpu_ce     : CPU clock enable (controller -> CPU)
//   watch_stat : CPU FSM state    (CPU -> controller)
//   watch_pc   : CPU program counter (CPU -> controller)
// modport master : the debug controller
// modport slave  : the CPU core
// -----------------------------------------------------------------------------
interface cpu_debug_ctrl_if;
    logic        cpu_ce;
    logic [3:0]  watch_stat;
    logic [31:0] watch_pc;

    modport master (output cpu_ce, input  watch_stat, input  watch_pc);
    modport slave  (input  cpu_ce, output watch_stat, output watch_pc);
endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronises a raw push button, filters bounce and emits a one-cycle pulse
// on each accepted press. Releases are filtered the same way but emit nothing.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_btn      : raw asynchronous button level
//   o_press    : registered 1-cycle pulse on the filtered rising edge
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_level;
    logic [19:0] r_cnt;
    logic        r_press;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, making the two-stage synchroniser a real shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_level) begin
                // The DEBOUNCE_CYCLES-th consecutive differing sample flips the level.
                if (r_cnt == DEBOUNCE_CYCLES - 20'd1) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    r_press <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + 20'd1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/cpu_debug_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_debug_ctrl
// Run / single-cycle / single-instruction / halt controller for the multi-cycle
// RISC-V CPU, with PC breakpoint, cycle and instruction counters and the LED
// watch-mux select (manual switches or auto-scan).
//   cpu_clk, rst   : clock, asynchronous active-low reset
//   btn_step/run   : raw buttons (debounced internally)
//   sw_step_inst   : step granularity (0 cycle, 1 instruction)
//   bp_en, bp_addr : PC breakpoint
//   sw_auto_scan, sw_sel : watch-select source
//   cpu_bus        : cpu_ce out, watch_stat / watch_pc in
//   halted, step_err, led_mux_sel, cycle_count, inst_count : status outputs
// -----------------------------------------------------------------------------
module cpu_debug_ctrl
    import cpu_debug_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
    parameter logic [31:0] DWELL_CYCLES    = 32'd50000000,
    parameter logic [3:0]  FETCH_STAT      = FETCH_STAT_DEFAULT,
    parameter logic [7:0]  STEP_TIMEOUT    = 8'd32
) (
    input  logic                    cpu_clk,
    input  logic                    rst,
    input  logic                    btn_step,
    input  logic                    btn_run,
    input  logic                    sw_step_inst,
    input  logic                    bp_en,
    input  logic [31:0]             bp_addr,
    input  logic                    sw_auto_scan,
    input  logic [3:0]              sw_sel,
    cpu_debug_ctrl_if.master        cpu_bus,
    output logic                    halted,
    output logic                    step_err,
    output logic [3:0]              led_mux_sel,
    output logic [31:0]             cycle_count,
    output logic [31:0]             inst_count
);

    logic        w_step_press;
    logic        w_run_press;
    logic        w_boundary;
    logic        w_bp_hit;
    logic        w_cpu_ce;

    state_t      r_state;
    logic        r_halted;
    logic        r_moved;
    logic [7:0]  r_to_cnt;
    logic        r_step_err;
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_inst_cnt;
    logic [3:0]  r_led_sel;
    logic [31:0] r_dwell_cnt;
    logic        r_scan_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk     (cpu_clk),
        .rst_n   (rst),
        .i_btn   (btn_step),
        .o_press (w_step_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk     (cpu_clk),
        .rst_n   (rst),
        .i_btn   (btn_run),
        .o_press (w_run_press)
    );

    assign w_boundary = (cpu_bus.watch_stat == FETCH_STAT);
    assign w_bp_hit   = bp_en && w_boundary && (cpu_bus.watch_pc == bp_addr);

    // cpu_ce is the one combinational output: the CPU must be frozen in the
    // very cycle it reaches the next fetch or the breakpoint, not one later.
    // 'moved' keeps the starting fetch cycle from counting as the stop point.
    always_comb begin
        // NOTE: default first so every path assigns w_cpu_ce and no latch forms.
        w_cpu_ce = 1'b0;
        case (r_state)
            HALT:      w_cpu_ce = 1'b0;
            STEP_CYC:  w_cpu_ce = 1'b1;
            STEP_INST: w_cpu_ce = !(r_moved && w_boundary);
            RUN:       w_cpu_ce = !(r_moved && w_bp_hit);
            default:   w_cpu_ce = 1'b0;
        endcase
    end

    assign cpu_bus.cpu_ce = w_cpu_ce;

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            r_state    <= HALT;
            r_halted   <= 1'b1;
            r_moved    <= 1'b0;
            r_to_cnt   <= '0;
            r_step_err <= 1'b0;
        end else begin
            case (r_state)
                HALT: begin
                    if (w_run_press) begin
                        r_state  <= RUN;
                        r_halted <= 1'b0;
                        r_moved  <= 1'b0;
                    end else if (w_step_press) begin
                        r_state  <= sw_step_inst ? STEP_INST : STEP_CYC;
                        r_halted <= 1'b0;
                        r_moved  <= 1'b0;
                        r_to_cnt <= '0;
                    end
                end
                STEP_CYC: begin
                    r_state  <= HALT;
                    r_halted <= 1'b1;
                end
                STEP_INST: begin
                    if (!w_cpu_ce) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_moved  <= 1'b1;
                        r_to_cnt <= r_to_cnt + 8'd1;
                        if (r_to_cnt + 8'd1 == STEP_TIMEOUT) begin
                            r_state    <= HALT;
                            r_halted   <= 1'b1;
                            r_step_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_cpu_ce) begin
                        r_moved <= 1'b1;
                    end
                    if (!w_cpu_ce || w_run_press) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= HALT;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            r_cycle_cnt <= '0;
            r_inst_cnt  <= '0;
        end else if (w_cpu_ce) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_boundary) begin
                r_inst_cnt <= r_inst_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            r_led_sel   <= WSEL_STAT;
            r_dwell_cnt <= '0;
            r_scan_d    <= 1'b0;
        end else begin
            r_scan_d <= sw_auto_scan;
            if (!sw_auto_scan) begin
                r_led_sel   <= sw_sel;
                r_dwell_cnt <= '0;
            end else if (!r_scan_d) begin
                r_led_sel   <= WSEL_STAT;
                r_dwell_cnt <= '0;
            end else if (r_dwell_cnt == DWELL_CYCLES - 32'd1) begin
                r_dwell_cnt <= '0;
                r_led_sel   <= (r_led_sel == WSEL_PC_UPDATE_SEL) ? WSEL_STAT
                                                                 : r_led_sel + 4'd1;
            end else begin
                r_dwell_cnt <= r_dwell_cnt + 32'd1;
            end
        end
    end

    assign halted      = r_halted;
    assign step_err    = r_step_err;
    assign led_mux_sel = r_led_sel;
    assign cycle_count = r_cycle_cnt;
    assign inst_count  = r_inst_cnt;

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_debug_ctrl
// Drives cpu_debug_ctrl against a tiny CPU model: watch_stat runs 0..4 and the
// PC advances by 4 on each wrap to 0 (or watch_stat is pinned to 2 when stuck).
// Expected values are queued when stimulus is applied and popped on checking.
// -----------------------------------------------------------------------------
module tb_cpu_debug_ctrl;

    logic        clk;
    logic        rst_n;
    logic        btn_step;
    logic        btn_run;
    logic        sw_step_inst;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic        sw_auto_scan;
    logic [3:0]  sw_sel;
    logic        halted;
    logic        step_err;
    logic [3:0]  led_mux_sel;
    logic [31:0] cycle_count;
    logic [31:0] inst_count;

    logic        stuck;
    logic [3:0]  m_stat;
    logic [31:0] m_pc;

    int          checks;
    int          errors;
    int          ce_seen;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    cpu_debug_ctrl_if cpu_if();

    cpu_debug_ctrl #(
        .DEBOUNCE_CYCLES(20'd4),
        .DWELL_CYCLES   (32'd8),
        .FETCH_STAT     (4'd0),
        .STEP_TIMEOUT   (8'd8)
    ) u_dut (
        .cpu_clk      (clk),
        .rst          (rst_n),
        .btn_step     (btn_step),
        .btn_run      (btn_run),
        .sw_step_inst (sw_step_inst),
        .bp_en        (bp_en),
        .bp_addr      (bp_addr),
        .sw_auto_scan (sw_auto_scan),
        .sw_sel       (sw_sel),
        .cpu_bus      (cpu_if),
        .halted       (halted),
        .step_err     (step_err),
        .led_mux_sel  (led_mux_sel),
        .cycle_count  (cycle_count),
        .inst_count   (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CPU model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stat <= 4'd0;
            m_pc   <= 32'd0;
        end else if (cpu_if.cpu_ce) begin
            if (m_stat == 4'd4) begin
                m_stat <= 4'd0;
                m_pc   <= m_pc + 32'd4;
            end else begin
                m_stat <= m_stat + 4'd1;
            end
        end
    end
    assign cpu_if.watch_stat = stuck ? 4'd2 : m_stat;
    assign cpu_if.watch_pc   = m_pc;

    // Count enabled cycles as the CPU sees them (value just before each edge).
    initial ce_seen = 0;
    always @(posedge clk) if (cpu_if.cpu_ce === 1'b1) ce_seen = ce_seen + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic press(input logic is_run, input int hold);
        if (is_run) btn_run = 1'b1; else btn_step = 1'b1;
        tick(hold);
        btn_run  = 1'b0;
        btn_step = 1'b0;
    endtask

    task automatic wait_halted(input logic level, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (halted === level) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, halted} !== exp_v) begin errors++; $display("FAIL reset_halted got %0d want %0d", halted, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, cpu_if.cpu_ce} !== exp_v) begin errors++; $display("FAIL reset_ce got %0d want %0d", cpu_if.cpu_ce, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (cycle_count !== exp_v) begin errors++; $display("FAIL reset_cycles got %0d want %0d", cycle_count, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (inst_count !== exp_v) begin errors++; $display("FAIL reset_insts got %0d want %0d", inst_count, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({28'd0, led_mux_sel} !== exp_v) begin errors++; $display("FAIL reset_led got %0d want %0d", led_mux_sel, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, step_err} !== exp_v) begin errors++; $display("FAIL reset_err got %0d want %0d", step_err, exp_v); end
        tick(2);
        rst_n = 1'b1;
        #1;
        checks++;
        if (cpu_if.cpu_ce !== 1'b0) begin errors++; $display("FAIL reset_release_ce got %0d want 0", cpu_if.cpu_ce); end
        tick(1);
    endtask

    task automatic test_glitch();
        int ce0;
        ce0 = ce_seen;
        exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        press(1'b0, 3);
        tick(20);
        exp_v = exp_q.pop_front(); checks++;
        if (32'(ce_seen - ce0) !== exp_v) begin errors++; $display("FAIL glitch_ce got %0d want %0d", ce_seen - ce0, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, halted} !== exp_v) begin errors++; $display("FAIL glitch_halted got %0d want %0d", halted, exp_v); end
    endtask

    task automatic test_step_cycle();
        int ce0;
        ce0 = ce_seen;
        sw_step_inst = 1'b0;
        exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        press(1'b0, 10);
        tick(20);
        exp_v = exp_q.pop_front(); checks++;
        if (32'(ce_seen - ce0) !== exp_v) begin errors++; $display("FAIL stepc_ce got %0d want %0d", ce_seen - ce0, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (cycle_count !== exp_v) begin errors++; $display("FAIL stepc_cycles got %0d want %0d", cycle_count, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (inst_count !== exp_v) begin errors++; $display("FAIL stepc_insts got %0d want %0d", inst_count, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, halted} !== exp_v) begin errors++; $display("FAIL stepc_halted got %0d want %0d", halted, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({28'd0, cpu_if.watch_stat} !== exp_v) begin errors++; $display("FAIL stepc_stat got %0d want %0d", cpu_if.watch_stat, exp_v); end
    endtask

    task automatic test_step_inst();
        int ce0;
        do_reset();
        sw_step_inst = 1'b1;
        for (int n = 1; n <= 2; n++) begin
            ce0 = ce_seen;
            exp_q.push_back(32'd5);
            exp_q.push_back(32'd0);
            exp_q.push_back(32'(4 * n));
            exp_q.push_back(32'(n));
            exp_q.push_back(32'(5 * n));
            press(1'b0, 10);
            tick(25);
            exp_v = exp_q.pop_front(); checks++;
            if (32'(ce_seen - ce0) !== exp_v) begin errors++; $display("FAIL stepi_ce got %0d want %0d", ce_seen - ce0, exp_v); end
            exp_v = exp_q.pop_front(); checks++;
            if ({28'd0, cpu_if.watch_stat} !== exp_v) begin errors++; $display("FAIL stepi_stat got %0d want %0d", cpu_if.watch_stat, exp_v); end
            exp_v = exp_q.pop_front(); checks++;
            if (cpu_if.watch_pc !== exp_v) begin errors++; $display("FAIL stepi_pc got %0h want %0h", cpu_if.watch_pc, exp_v); end
            exp_v = exp_q.pop_front(); checks++;
            if (inst_count !== exp_v) begin errors++; $display("FAIL stepi_insts got %0d want %0d", inst_count, exp_v); end
            exp_v = exp_q.pop_front(); checks++;
            if (cycle_count !== exp_v) begin errors++; $display("FAIL stepi_cycles got %0d want %0d", cycle_count, exp_v); end
        end
        sw_step_inst = 1'b0;
    endtask

    task automatic test_breakpoint();
        bit ok;
        int ce0;
        do_reset();
        bp_en   = 1'b1;
        bp_addr = 32'h0000_000C;
        exp_q.push_back(32'h0C); exp_q.push_back(32'd0); exp_q.push_back(32'd3);
        exp_q.push_back(32'd15);
        press(1'b1, 10);
        wait_halted(1'b1, 60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_halt_timeout got halted=%0d want 1", halted); end
        exp_v = exp_q.pop_front(); checks++;
        if (cpu_if.watch_pc !== exp_v) begin errors++; $display("FAIL bp_pc got %0h want %0h", cpu_if.watch_pc, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({28'd0, cpu_if.watch_stat} !== exp_v) begin errors++; $display("FAIL bp_stat got %0d want %0d", cpu_if.watch_stat, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (inst_count !== exp_v) begin errors++; $display("FAIL bp_insts got %0d want %0d", inst_count, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (cycle_count !== exp_v) begin errors++; $display("FAIL bp_cycles got %0d want %0d", cycle_count, exp_v); end
        tick(10);
        // Resume from the breakpointed PC.
        press(1'b1, 10);
        wait_halted(1'b0, 30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_resume_timeout got halted=%0d want 0", halted); end
        tick(10);
        exp_q.push_back(32'd1);
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, (cpu_if.watch_pc > 32'h0C)} !== exp_v) begin errors++; $display("FAIL bp_resume_pc got %0h want >c", cpu_if.watch_pc); end
        // Pause with the run button, then confirm the CPU stays frozen.
        press(1'b1, 10);
        wait_halted(1'b1, 30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_pause_timeout got halted=%0d want 1", halted); end
        ce0 = ce_seen;
        tick(8);
        checks++;
        if (ce_seen != ce0) begin errors++; $display("FAIL bp_pause_ce got %0d want 0", ce_seen - ce0); end
        // Reset while running: CPU must not be enabled during or just after it.
        tick(10);
        press(1'b1, 10);
        wait_halted(1'b0, 30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midrst_run_timeout got halted=%0d want 0", halted); end
        tick(3);
        rst_n = 1'b0;
        #1;
        checks++;
        if (cpu_if.cpu_ce !== 1'b0) begin errors++; $display("FAIL midrst_ce got %0d want 0", cpu_if.cpu_ce); end
        tick(2);
        rst_n = 1'b1;
        #1;
        checks++;
        if (cpu_if.cpu_ce !== 1'b0) begin errors++; $display("FAIL midrst_release_ce got %0d want 0", cpu_if.cpu_ce); end
        tick(1);
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL midrst_halted got %0d want 1", halted); end
        bp_en = 1'b0;
        tick(10);
    endtask

    task automatic test_timeout();
        int ce0;
        do_reset();
        stuck = 1'b1;
        sw_step_inst = 1'b1;
        ce0 = ce_seen;
        exp_q.push_back(32'd8); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        press(1'b0, 10);
        tick(30);
        exp_v = exp_q.pop_front(); checks++;
        if (32'(ce_seen - ce0) !== exp_v) begin errors++; $display("FAIL to_ce got %0d want %0d", ce_seen - ce0, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, step_err} !== exp_v) begin errors++; $display("FAIL to_err got %0d want %0d", step_err, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, halted} !== exp_v) begin errors++; $display("FAIL to_halted got %0d want %0d", halted, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (inst_count !== exp_v) begin errors++; $display("FAIL to_insts got %0d want %0d", inst_count, exp_v); end
        // A later cycle step leaves the sticky error in place.
        sw_step_inst = 1'b0;
        exp_q.push_back(32'd1);
        press(1'b0, 10);
        tick(20);
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, step_err} !== exp_v) begin errors++; $display("FAIL to_sticky got %0d want %0d", step_err, exp_v); end
        do_reset();
        checks++;
        if (step_err !== 1'b0) begin errors++; $display("FAIL to_clear got %0d want 0", step_err); end
        stuck = 1'b0;
    endtask

    task automatic test_auto_scan();
        sw_sel = 4'd5;
        sw_auto_scan = 1'b0;
        tick(2);
        checks++;
        if (led_mux_sel !== 4'd5) begin errors++; $display("FAIL scan_manual got %0d want 5", led_mux_sel); end
        sw_auto_scan = 1'b1;
        for (int k = 0; k < 132; k++) begin
            exp_q.push_back(32'((k / 8) % 16));
            tick(1);
            exp_v = exp_q.pop_front(); checks++;
            if ({28'd0, led_mux_sel} !== exp_v) begin errors++; $display("FAIL scan_k%0d got %0d want %0d", k, led_mux_sel, exp_v); end
        end
        sw_auto_scan = 1'b0;
        tick(1);
        checks++;
        if (led_mux_sel !== 4'd5) begin errors++; $display("FAIL scan_off got %0d want 5", led_mux_sel); end
        // Manual select is registered: old value until the next edge.
        sw_sel = 4'd9;
        #1;
        checks++;
        if (led_mux_sel !== 4'd5) begin errors++; $display("FAIL manual_before got %0d want 5", led_mux_sel); end
        tick(1);
        checks++;
        if (led_mux_sel !== 4'd9) begin errors++; $display("FAIL manual_after got %0d want 9", led_mux_sel); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b1;
        btn_step     = 1'b0;
        btn_run      = 1'b0;
        sw_step_inst = 1'b0;
        bp_en        = 1'b0;
        bp_addr      = 32'd0;
        sw_auto_scan = 1'b0;
        sw_sel       = 4'd0;
        stuck        = 1'b0;

        test_reset();
        test_glitch();
        test_step_cycle();
        test_step_inst();
        test_breakpoint();
        test_timeout();
        test_auto_scan();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
